// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the bimodal branch predictor: counter encodings,
// resolution status codes, FSM states and the saturating-update helper.
package branch_predictor_pkg;

  // 2-bit saturating counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Resolution status codes produced by the EX stage
  localparam logic [1:0] PS_MISS_NT = 2'd0;  // predicted not-taken, was taken
  localparam logic [1:0] PS_MISS_T  = 2'd1;  // predicted taken, was not-taken
  localparam logic [1:0] PS_HIT_NT  = 2'd2;  // predicted not-taken, was not-taken
  localparam logic [1:0] PS_HIT_T   = 2'd3;  // predicted taken, was taken

  // Controller states
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Saturating increment on taken, decrement on not-taken
  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

  // True for the two miss codes only
  function automatic logic is_mispredict(input logic [1:0] status);
    logic miss;
    case (status)
      PS_MISS_NT, PS_MISS_T: miss = 1'b1;
      PS_HIT_NT,  PS_HIT_T:  miss = 1'b0;
      default:               miss = 1'b0;
    endcase
    return miss;
  endfunction

endpackage

// File: rtl/branch_predictor_counter_table.sv
// Counter storage: 2**INDEX_BITS x 2 bits, two asynchronous read ports
// (fetch lookup, resolution lookup) and one synchronous write port.
// Storage is not reset; the controller initialises it after reset.
module branch_predictor_counter_table #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [1:0]            wdata,
  input  logic [INDEX_BITS-1:0] if_addr,
  output logic [1:0]            if_data,
  input  logic [INDEX_BITS-1:0] ex_addr,
  output logic [1:0]            ex_data
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [1:0] mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read ports
  assign if_data = mem[if_addr];
  assign ex_data = mem[ex_addr];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters indexed by
// fetch PC, retrained from EX-stage resolution, with misprediction counters.
// Optional feature macro: BP_GSHARE_EN (XOR a global history register into
// the fetch index).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 6,
  parameter logic [1:0]  RESET_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IF_valid,
  input  logic [31:0]           IF_pc,
  output logic [1:0]            IF_branch_prediction,
  output logic                  IF_predict_taken,
  output logic [INDEX_BITS-1:0] IF_bp_index,
  output logic                  ready,
  input  logic                  EX_Branch,
  input  logic [INDEX_BITS-1:0] EX_bp_index,
  input  logic                  branch_taken,
  input  logic [1:0]            prediction_status,
  output logic                  mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  state_e                state;
  state_e                state_next;
  logic [INDEX_BITS-1:0] init_ptr;
  logic [INDEX_BITS-1:0] init_ptr_next;

  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_waddr;
  logic [1:0]            tbl_wdata;
  logic [1:0]            if_rd;
  logic [1:0]            ex_rd;
  logic [1:0]            ex_new;

  logic [INDEX_BITS-1:0] if_idx;
  logic                  upd;
  logic                  bypass;
  logic                  unused_pc_bits;

  // Fetch PC bits outside the index field carry no information here
  assign unused_pc_bits = ^{IF_pc[31:INDEX_BITS+2], IF_pc[1:0]};

  assign ready  = (state == S_RUN);
  assign upd    = ready & EX_Branch;
  assign ex_new = sat_update(ex_rd, branch_taken);

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // Global history: shift in each resolved outcome
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd) begin
      ghr <= {ghr[INDEX_BITS-2:0], branch_taken};
    end
  end

  assign if_idx = IF_pc[INDEX_BITS+1:2] ^ ghr;
`else
  assign if_idx = IF_pc[INDEX_BITS+1:2];
`endif

  assign IF_bp_index = if_idx;

  branch_predictor_counter_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we),
    .waddr   (tbl_waddr),
    .wdata   (tbl_wdata),
    .if_addr (if_idx),
    .if_data (if_rd),
    .ex_addr (EX_bp_index),
    .ex_data (ex_rd)
  );

  // State and init pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
    end
  end

  // Next state and table write selection: sweep during init, train in run
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    tbl_we        = 1'b0;
    tbl_waddr     = EX_bp_index;
    tbl_wdata     = ex_new;
    case (state)
      S_INIT: begin
        tbl_we        = 1'b1;
        tbl_waddr     = init_ptr;
        tbl_wdata     = RESET_STATE;
        init_ptr_next = init_ptr + INDEX_BITS'(1);
        if (init_ptr == {INDEX_BITS{1'b1}}) state_next = S_RUN;
      end
      S_RUN: begin
        tbl_we = EX_Branch;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  // Same-cycle bypass so fetch never sees a counter about to be overwritten
  assign bypass = upd & IF_valid & (if_idx == EX_bp_index);

  // Prediction output; fixed weakly-not-taken until the table is initialised
  always_comb begin
    IF_branch_prediction = WNT;
    if (ready) IF_branch_prediction = bypass ? ex_new : if_rd;
  end

  assign IF_predict_taken = IF_branch_prediction[1] & ready;

  // Misprediction pulse and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= upd & is_mispredict(prediction_status);
      if (upd) begin
        branch_count <= branch_count + 32'd1;
        if (is_mispredict(prediction_status)) mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default bimodal build).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        IF_valid;
  logic [31:0] IF_pc;
  logic [1:0]  IF_branch_prediction;
  logic        IF_predict_taken;
  logic [5:0]  IF_bp_index;
  logic        ready;
  logic        EX_Branch;
  logic [5:0]  EX_bp_index;
  logic        branch_taken;
  logic [1:0]  prediction_status;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(
    .INDEX_BITS  (6),
    .RESET_STATE (2'b01)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .IF_valid             (IF_valid),
    .IF_pc                (IF_pc),
    .IF_branch_prediction (IF_branch_prediction),
    .IF_predict_taken     (IF_predict_taken),
    .IF_bp_index          (IF_bp_index),
    .ready                (ready),
    .EX_Branch            (EX_Branch),
    .EX_bp_index          (EX_bp_index),
    .branch_taken         (branch_taken),
    .prediction_status    (prediction_status),
    .mispredict           (mispredict),
    .branch_count         (branch_count),
    .mispredict_count     (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        br;
    logic [5:0]  idx;
    logic        taken;
    logic [1:0]  status;
    logic [1:0]  exp_pred;
    logic        exp_mp;
  } vec_t;

  typedef struct {
    logic        mp;
    logic [31:0] bc;
    logic [31:0] mc;
  } sb_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] bc_exp;
  logic [31:0] mc_exp;
  sb_t         sbq[$];
  vec_t        vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    IF_valid          = 1'b0;
    IF_pc             = 32'h0;
    EX_Branch         = 1'b0;
    EX_bp_index       = 6'd0;
    branch_taken      = 1'b0;
    prediction_status = 2'd0;
  endtask

  // Hold reset for some cycles, check reset outputs, then release
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pred", 32'(IF_branch_prediction), 32'h1);
    chk("rst_ptaken", 32'(IF_predict_taken), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_branch_count", branch_count, 32'd0);
    chk("rst_mispredict_count", mispredict_count, 32'd0);
    bc_exp = 32'd0;
    mc_exp = 32'd0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count rising edges until ready; bounded
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        break;
      end
    end
    chk(name, 32'(n), 32'd64);
  endtask

  // Drive one vector, check fetch side, then check registered results
  task automatic apply(input vec_t v, input int k);
    sb_t e;
    @(negedge clk);
    IF_pc             = v.pc;
    IF_valid          = v.valid;
    EX_Branch         = v.br;
    EX_bp_index       = v.idx;
    branch_taken      = v.taken;
    prediction_status = v.status;
    #1;
    chk($sformatf("v%0d_pred", k), 32'(IF_branch_prediction), 32'(v.exp_pred));
    chk($sformatf("v%0d_ptaken", k), 32'(IF_predict_taken), 32'(v.exp_pred[1]));
    chk($sformatf("v%0d_index", k), 32'(IF_bp_index), 32'(v.pc[7:2]));
    bc_exp = bc_exp + 32'(v.br);
    mc_exp = mc_exp + 32'(v.br & ~v.status[1]);
    sbq.push_back('{mp: v.exp_mp, bc: bc_exp, mc: mc_exp});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", k), 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d_mispredict", k), 32'(mispredict), 32'(e.mp));
      chk($sformatf("v%0d_branch_count", k), branch_count, e.bc);
      chk($sformatf("v%0d_mispredict_count", k), mispredict_count, e.mc);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pc        val   br    idx    tkn   st     pred   mp
    vecs[0]  = '{32'h00, 1'b1, 1'b1, 6'd9, 1'b1, 2'd0, 2'b01, 1'b1};
    vecs[1]  = '{32'h00, 1'b1, 1'b1, 6'd9, 1'b0, 2'd1, 2'b01, 1'b1};
    vecs[2]  = '{32'h00, 1'b1, 1'b1, 6'd9, 1'b0, 2'd2, 2'b01, 1'b0};
    vecs[3]  = '{32'h00, 1'b1, 1'b1, 6'd9, 1'b1, 2'd3, 2'b01, 1'b0};
    vecs[4]  = '{32'h00, 1'b1, 1'b1, 6'd9, 1'b1, 2'd0, 2'b01, 1'b1};
    vecs[5]  = '{32'h24, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 2'b10, 1'b0};
    vecs[6]  = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 2'd3, 2'b10, 1'b0};
    vecs[7]  = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 2'd3, 2'b11, 1'b0};
    vecs[8]  = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 2'd3, 2'b11, 1'b0};
    vecs[9]  = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b1, 2'd3, 2'b11, 1'b0};
    vecs[10] = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 2'd2, 2'b10, 1'b0};
    vecs[11] = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 2'd2, 2'b01, 1'b0};
    vecs[12] = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 2'd2, 2'b00, 1'b0};
    vecs[13] = '{32'h14, 1'b1, 1'b1, 6'd5, 1'b0, 2'd2, 2'b00, 1'b0};
    vecs[14] = '{32'h14, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 2'b00, 1'b0};
    vecs[15] = '{32'h14, 1'b0, 1'b1, 6'd5, 1'b1, 2'd0, 2'b00, 1'b1};
    vecs[16] = '{32'h14, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 2'b01, 1'b0};
    vecs[17] = '{32'h14, 1'b1, 1'b1, 6'd6, 1'b1, 2'd3, 2'b01, 1'b0};
    vecs[18] = '{32'h18, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 2'b10, 1'b0};

    rst = 1'b1;
    idle_inputs();
    bc_exp = 32'd0;
    mc_exp = 32'd0;

    // Reset and full init; EX activity during init must be ignored
    do_reset(2);
    EX_Branch         = 1'b1;
    EX_bp_index       = 6'd5;
    branch_taken      = 1'b1;
    prediction_status = 2'd0;
    wait_ready("init_ready_latency");
    chk("init_branch_count", branch_count, 32'd0);
    chk("init_mispredict_count", mispredict_count, 32'd0);
    chk("init_mispredict", 32'(mispredict), 32'd0);
    @(negedge clk);
    idle_inputs();

    // Every entry initialised to weakly not-taken; upper PC bits ignored
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      IF_valid = 1'b1;
      IF_pc    = 32'h0000_1000 | (32'(i) << 2);
      #1;
      chk($sformatf("init_entry%0d", i), 32'(IF_branch_prediction), 32'h1);
      chk($sformatf("init_index%0d", i), 32'(IF_bp_index), 32'(i));
    end

    // Status stream 0,1,2,3,0 on index 9
    for (int k = 0; k < 5; k++) apply(vecs[k], k);
    chk("stream_branch_count", branch_count, 32'd5);
    chk("stream_mispredict_count", mispredict_count, 32'd3);

    // Readback, saturation with bypass, IF_valid gating, other-index update
    for (int k = 5; k < 19; k++) apply(vecs[k], k);

    // Reset while running clears counts
    do_reset(1);

    // Reset in the middle of init restarts the sweep
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("reinit_ready_latency");
    @(negedge clk);
    IF_valid = 1'b1;
    IF_pc    = 32'h14;
    #1;
    chk("reinit_entry5", 32'(IF_branch_prediction), 32'h1);
    IF_pc = 32'h18;
    #1;
    chk("reinit_entry6", 32'(IF_branch_prediction), 32'h1);
    chk("reinit_branch_count", branch_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
